// File: rtl/ex_mdu_ctrl_pkg.sv
// rtl/ex_mdu_ctrl_pkg.sv - shared types and constants for the RV32M multiply/divide sequencer
// Purpose: fun3 op codes, FSM state encoding, widths and operand-signedness helpers.
// Ports: none (package).
// Width override: define XLEN before compilation to change the datapath width.
`ifndef XLEN
`define XLEN 32
`endif

package ex_mdu_ctrl_pkg;

   localparam int XLEN  = `XLEN;
   localparam int CNT_W = 6;

   localparam logic [6:0]      MDU_FUN7 = 7'b0000001;
   localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [2:0] MDU_MUL    = 3'd0;
   localparam logic [2:0] MDU_MULH   = 3'd1;
   localparam logic [2:0] MDU_MULHSU = 3'd2;
   localparam logic [2:0] MDU_MULHU  = 3'd3;
   localparam logic [2:0] MDU_DIV    = 3'd4;
   localparam logic [2:0] MDU_DIVU   = 3'd5;
   localparam logic [2:0] MDU_REM    = 3'd6;
   localparam logic [2:0] MDU_REMU   = 3'd7;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_CALC = 2'd1,
      MDU_FIX  = 2'd2,
      MDU_DONE = 2'd3
   } mdu_state_e;

   // MUL only needs the low word, which is sign-agnostic, so it is run unsigned.
   function automatic logic rs1_signed(input logic [2:0] fun3);
      return (fun3 == MDU_MULH) || (fun3 == MDU_MULHSU) ||
             (fun3 == MDU_DIV)  || (fun3 == MDU_REM);
   endfunction

   function automatic logic rs2_signed(input logic [2:0] fun3);
      return (fun3 == MDU_MULH) || (fun3 == MDU_DIV) || (fun3 == MDU_REM);
   endfunction

endpackage

// File: rtl/ex_mdu_ctrl_if.sv
// rtl/ex_mdu_ctrl_if.sv - EX-stage request/response bundle for the multiply/divide sequencer
// Purpose: groups the EX request, flush and result/stall signals.
// Signals: req_i, fun3_i, rs1_i, rs2_i, flush_i (EX -> MDU); stall_o, res_valid_o, res_o (MDU -> EX).
// Modports: master = EX stage, slave = MDU.
interface ex_mdu_ctrl_if;
   import ex_mdu_ctrl_pkg::*;

   logic            req_i;
   logic [2:0]      fun3_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic            flush_i;
   logic            stall_o;
   logic            res_valid_o;
   logic [XLEN-1:0] res_o;

   modport master (
      output req_i, fun3_i, rs1_i, rs2_i, flush_i,
      input  stall_o, res_valid_o, res_o
   );

   modport slave (
      input  req_i, fun3_i, rs1_i, rs2_i, flush_i,
      output stall_o, res_valid_o, res_o
   );

endinterface

// File: rtl/ex_mdu_ctrl_mdu_step.sv
// rtl/ex_mdu_ctrl_mdu_step.sv - one combinational iteration of the shared multiply/divide datapath
// Purpose: radix-2 shift-add (multiply) or restoring shift-subtract (divide) step.
// Ports: i_acc {hi,lo} accumulator, i_op multiplicand/divisor, i_div mode select, o_acc next accumulator.
module ex_mdu_ctrl_mdu_step
   import ex_mdu_ctrl_pkg::*;
(
   input  logic [2*XLEN-1:0] i_acc,
   input  logic [XLEN-1:0]   i_op,
   input  logic              i_div,
   output logic [2*XLEN-1:0] o_acc
);

   logic [XLEN-1:0] w_hi;
   logic [XLEN-1:0] w_lo;
   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_rem;
   logic [XLEN:0]   w_diff;

   assign w_hi   = i_acc[2*XLEN-1:XLEN];
   assign w_lo   = i_acc[XLEN-1:0];
   // Multiply: lo holds the remaining multiplier bits; carry of the add shifts into hi.
   assign w_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_op} : {(XLEN+1){1'b0}});
   // Divide: partial remainder stays below the divisor, so rem < 2*op and the
   // difference never needs more than XLEN bits; its top bit is the borrow.
   assign w_rem  = {w_hi, w_lo[XLEN-1]};
   assign w_diff = w_rem - {1'b0, i_op};

   always_comb begin
      o_acc = i_acc;
      if (!i_div) begin
         o_acc = {w_sum, w_lo[XLEN-1:1]};
      end else if (!w_diff[XLEN]) begin
         o_acc = {w_diff[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};
      end else begin
         o_acc = {w_rem[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/ex_mdu_ctrl.sv
// rtl/ex_mdu_ctrl.sv - multi-cycle RV32M multiply/divide sequencer for the EX stage
// Purpose: accepts an M-op, stalls the pipeline while iterating, returns one result pulse.
// Ports: clk, rst_n (async active-low), bus (ex_mdu_ctrl_if.slave).
// Option: MDU_FAST_MUL_EN selects a single-cycle multiplier for MUL/MULH/MULHSU/MULHU.
module ex_mdu_ctrl
   import ex_mdu_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   ex_mdu_ctrl_if.slave bus
);

   mdu_state_e        r_state;
   logic [2:0]        r_fun3;
   logic [CNT_W-1:0]  r_cnt;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_op;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_res_valid;
   logic [XLEN-1:0]   r_res;

   logic              w_s1;
   logic              w_s2;
   logic              w_is_div;
   logic              w_div0;
   logic              w_ovf;
   logic              w_accept;
   logic [XLEN-1:0]   w_abs1;
   logic [XLEN-1:0]   w_abs2;
   logic [XLEN-1:0]   w_special;
   logic [2*XLEN-1:0] w_step_acc;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_fix_res;

   assign w_s1     = rs1_signed(bus.fun3_i) & bus.rs1_i[XLEN-1];
   assign w_s2     = rs2_signed(bus.fun3_i) & bus.rs2_i[XLEN-1];
   assign w_abs1   = w_s1 ? -bus.rs1_i : bus.rs1_i;
   assign w_abs2   = w_s2 ? -bus.rs2_i : bus.rs2_i;
   assign w_is_div = bus.fun3_i[2];
   assign w_div0   = w_is_div && (bus.rs2_i == '0);
   // Only DIV/REM (fun3[0]=0) can overflow.
   assign w_ovf    = w_is_div && !bus.fun3_i[0] && (bus.rs1_i == MIN_INT) && (bus.rs2_i == '1);
   // fun3[1] distinguishes REM* from DIV* within the divide group.
   assign w_special = w_div0 ? (bus.fun3_i[1] ? bus.rs1_i : '1)
                             : (bus.fun3_i[1] ? '0 : MIN_INT);
   assign w_accept  = (r_state == MDU_IDLE) && bus.req_i && !bus.flush_i;

`ifdef MDU_FAST_MUL_EN
   logic [2*XLEN-1:0] w_fa;
   logic [2*XLEN-1:0] w_fb;
   logic [2*XLEN-1:0] w_fp;
   // w_s1/w_s2 are exactly the sign-extension bits of the 33-bit signed operands.
   assign w_fa = {{XLEN{w_s1}}, bus.rs1_i};
   assign w_fb = {{XLEN{w_s2}}, bus.rs2_i};
   assign w_fp = w_fa * w_fb;
`endif

   ex_mdu_ctrl_mdu_step u_step (
      .i_acc (r_acc),
      .i_op  (r_op),
      .i_div (r_fun3[2]),
      .o_acc (w_step_acc)
   );

   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quo  = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
   assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

   always_comb begin
      w_fix_res = '0;
      if (r_fun3[2]) begin
         w_fix_res = r_fun3[1] ? w_rem : w_quo;
      end else if (r_fun3 == MDU_MUL) begin
         w_fix_res = w_prod[XLEN-1:0];
      end else begin
         w_fix_res = w_prod[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= MDU_IDLE;
         r_fun3      <= '0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_op        <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_res_valid <= 1'b0;
         r_res       <= '0;
      end else begin
         r_res_valid <= 1'b0;
         if (bus.flush_i) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               MDU_IDLE: begin
                  if (bus.req_i) begin
                     r_fun3  <= bus.fun3_i;
                     r_cnt   <= '0;
                     r_acc   <= {{XLEN{1'b0}}, w_abs1};
                     r_op    <= w_abs2;
                     r_neg_q <= w_s1 ^ w_s2;
                     r_neg_r <= w_s1;
                     if (w_div0 || w_ovf) begin
                        r_res       <= w_special;
                        r_res_valid <= 1'b1;
                        r_state     <= MDU_DONE;
                     end
`ifdef MDU_FAST_MUL_EN
                     else if (!w_is_div) begin
                        // Product is already signed-correct; FIX only selects the word.
                        r_acc   <= w_fp;
                        r_neg_q <= 1'b0;
                        r_state <= MDU_FIX;
                     end
`endif
                     else begin
                        r_state <= MDU_CALC;
                     end
                  end
               end
               MDU_CALC: begin
                  r_acc <= w_step_acc;
                  if (r_cnt == CNT_W'(XLEN-1)) begin
                     r_state <= MDU_FIX;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               MDU_FIX: begin
                  r_res       <= w_fix_res;
                  r_res_valid <= 1'b1;
                  r_state     <= MDU_DONE;
               end
               MDU_DONE: begin
                  r_state <= MDU_IDLE;
               end
               default: begin
                  r_state <= MDU_IDLE;
               end
            endcase
         end
      end
   end

   // Low in DONE so EX advances on the edge that retires the result.
   assign bus.stall_o     = w_accept || (r_state == MDU_CALC) || (r_state == MDU_FIX);
   assign bus.res_valid_o = r_res_valid;
   assign bus.res_o       = r_res;

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// tb/tb_ex_mdu_ctrl.sv - directed self-checking bench for ex_mdu_ctrl
module tb_ex_mdu_ctrl;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 34;
`endif
   localparam int DIV_LAT = 34;
   localparam int SPC_LAT = 1;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   ex_mdu_ctrl_if bus ();

   ex_mdu_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name);
      int cyc;
      int st;
      bus.req_i  = 1'b1;
      bus.fun3_i = f;
      bus.rs1_i  = a;
      bus.rs2_i  = b;
      #1;
      st  = bus.stall_o ? 1 : 0;
      cyc = 0;
      while (!bus.res_valid_o && cyc < 100) begin
         tick();
         cyc++;
         if (bus.stall_o) st++;
      end
      bus.req_i = 1'b0;
      chk({name, " latency"}, cyc, lat);
      chk({name, " stall cycles"}, st, lat);
      chk({name, " result"}, bus.res_o, exp);
      tick();
      chk({name, " pulse width"}, {31'b0, bus.res_valid_o}, 32'd0);
      chk({name, " hold"}, bus.res_o, exp);
   endtask

   initial begin
      int pulses;
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      bus.req_i   = 1'b0;
      bus.fun3_i  = 3'd0;
      bus.rs1_i   = '0;
      bus.rs2_i   = '0;
      bus.flush_i = 1'b0;

      tick();
      tick();
      chk("reset stall", {31'b0, bus.stall_o}, 32'd0);
      chk("reset valid", {31'b0, bus.res_valid_o}, 32'd0);
      chk("reset res", bus.res_o, 32'd0);
      rst_n = 1'b1;
      tick();

      run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "MUL 7*-3");
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "MULHU -1*-1");
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, "MULH -1*-1");
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "MULHSU -1*max");
      run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT, "DIV -7/2");
      run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT, "REM -7/2");
      run_op(3'd5, 32'h8000_0000, 32'h0000_0003, 32'h2AAA_AAAA, DIV_LAT, "DIVU min/3");
      run_op(3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, DIV_LAT, "REMU 100/7");
      run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT, "DIVU min/max");
      run_op(3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, SPC_LAT, "DIV 5/0");
      run_op(3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, SPC_LAT, "REM 5/0");
      run_op(3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, SPC_LAT, "DIVU 5/0");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT, "DIV ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT, "REM ovf");

      // Flush during CALC.
      bus.req_i  = 1'b1;
      bus.fun3_i = 3'd4;
      bus.rs1_i  = 32'd1000;
      bus.rs2_i  = 32'd3;
      tick();
      repeat (9) tick();
      chk("flush pre stall", {31'b0, bus.stall_o}, 32'd1);
      bus.flush_i = 1'b1;
      tick();
      chk("flush stall", {31'b0, bus.stall_o}, 32'd0);
      chk("flush valid", {31'b0, bus.res_valid_o}, 32'd0);
      bus.flush_i = 1'b0;
      bus.req_i   = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.res_valid_o) pulses++;
      end
      chk("flush no pulse", pulses, 0);
      chk("flush res kept", bus.res_o, 32'h0000_0000);
      run_op(3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT, "DIVU 100/7");

      // Flush in IDLE blocks acceptance.
      bus.req_i   = 1'b1;
      bus.flush_i = 1'b1;
      bus.fun3_i  = 3'd5;
      bus.rs1_i   = 32'd9;
      bus.rs2_i   = 32'd0;
      #1;
      chk("idle flush stall", {31'b0, bus.stall_o}, 32'd0);
      tick();
      chk("idle flush no accept", {31'b0, bus.res_valid_o}, 32'd0);
      chk("idle flush res", bus.res_o, 32'd14);
      bus.req_i   = 1'b0;
      bus.flush_i = 1'b0;
      tick();

      // Asynchronous reset mid-CALC.
      bus.req_i  = 1'b1;
      bus.fun3_i = 3'd5;
      bus.rs1_i  = 32'd50;
      bus.rs2_i  = 32'd5;
      repeat (6) tick();
      #2;
      rst_n     = 1'b0;
      bus.req_i = 1'b0;
      #1;
      chk("async rst stall", {31'b0, bus.stall_o}, 32'd0);
      chk("async rst valid", {31'b0, bus.res_valid_o}, 32'd0);
      chk("async rst res", bus.res_o, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      run_op(3'd0, 32'd6, 32'd7, 32'd42, MUL_LAT, "MUL 6*7");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ex_mdu_ctrl.md
Name: ex_mdu_ctrl

Overview:
- Multi-cycle sequencer for RV32M multiply/divide in the EX stage.
- Accepts an M-extension op from EX and stalls the pipeline while it iterates.
- Runs a shared shift-add/shift-subtract datapath, then returns one result for the EX result mux.
- Honours pipeline flushes from branch mispredicts.

Parameters:
- XLEN, `XLEN (32): operand and result width.
- CNT_W, 6: width of the iteration counter; must hold XLEN.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  1  EX holds an M-op (opcode AL, fun7=7'b0000001); held high while stall_o=1.
- fun3_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_i  in  XLEN  operand 1.
- rs2_i  in  XLEN  operand 2.
- flush_i  in  1  pipeline flush; kills any in-flight op.
- stall_o  out  1  freeze IF/ID/EX.
- res_valid_o  out  1  one-cycle pulse; res_o is valid.
- res_o  out  XLEN  result.

Behaviour:
- Reset: state=IDLE; stall_o=0, res_valid_o=0, res_o=0; all internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, req_i=1, flush_i=0:
  - Capture fun3 and the absolute values of operands for signed ops.
  - Record the result sign: quotient sign = s1^s2; remainder sign = s1.
  - cnt=0; go to CALC.
  - Special cases go directly to DONE:
    - Divide by zero: quotient = all ones; remainder = rs1.
    - Signed overflow (rs1=0x80000000, rs2=-1): quotient = 0x80000000; remainder = 0.
- CALC: one step per cycle; exactly XLEN cycles, then go to FIX.
  - Multiply: radix-2 shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract.
- FIX: apply two's-complement sign correction.
  - Select the low word (MUL), high word (MULH*), quotient or remainder.
  - Go to DONE.
- DONE: res_valid_o=1 for exactly one cycle; then go to IDLE.
- stall_o = (IDLE & req_i & ~flush_i) | CALC | FIX. Low in DONE so EX advances on that edge.
- Latency: normal op = XLEN+2 cycles from accept to res_valid_o (34 for 32-bit). Special-case divide = 1 cycle.
- flush_i in any state forces IDLE next cycle with no res_valid_o. flush_i in IDLE blocks the accept.
- Back-to-back requests: req_i seen in the cycle after DONE is a new instruction and is accepted.
- res_o holds its last value until the next FIX or special case.
- All arithmetic is modulo 2^XLEN. MULHSU treats only rs1 as signed.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a combinational 33x33 signed multiply. IDLE goes to FIX (1 cycle) then DONE, so latency = 2. Divide is unchanged.
- Undefined: all ops use the iterative path as above.

Decomposition:
- Into defines.v:
  - MDU fun3 codes: `MDU_MUL .. `MDU_REMU.
  - State encodings: `MDU_IDLE/CALC/FIX/DONE, 2 bits.
  - `MDU_FUN7.
- One sub-module, mdu_step: combinational single-iteration unit.
  - Inputs: accumulator, operand, mode.
  - Outputs: next accumulator.
  - Shared by multiply and divide.
- ex_mdu_ctrl owns the FSM, counter, sign fixup and stall logic.

Test Plan:
- MUL 7 * -3 (0x7, 0xFFFFFFFD) -> stall_o high 34 cycles, res_valid_o pulse, res_o=0xFFFFFFEB.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> res_o=0xFFFFFFFE; MULH on the same operands -> 0x00000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0x80000000/3 -> 0x2AAAAAAA.
- DIV 5/0 -> res_o=0xFFFFFFFF on the cycle after accept; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
- Start DIV, assert flush_i at CALC cycle 10 -> IDLE next cycle, stall_o=0, no res_valid_o. Next DIVU 100/7 -> 14.
- Assert rst_n=0 asynchronously mid-CALC -> outputs 0 immediately. With MDU_FAST_MUL_EN defined, MUL 6*7 -> res_o=42 with latency 2.
